// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, wrap/saturate boundary modes, tc pulse and sticky ovf.
// Optional count capture register enabled by defining PROG_COUNTER_CAPTURE_EN.
module prog_counter #(
  parameter int WIDTH = 32,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [PSC_W-1:0] psc_div,
  input  logic             cap,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic [WIDTH-1:0] cap_val
);

  logic [WIDTH-1:0] r_count;
  logic [PSC_W-1:0] r_psc;
  logic             r_tc;
  logic             r_ovf;

  logic             w_tick;
  logic             w_bound;
  logic [WIDTH-1:0] w_next;

  // Returns {boundary_hit, next_count} for one tick in the given direction/mode.
  function automatic logic [WIDTH:0] step_count(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] mx,
    input logic             up,
    input logic             sat_m
  );
    logic [WIDTH:0] res;
    if (up) begin
      if (cur >= mx) res = {1'b1, (sat_m ? mx : {WIDTH{1'b0}})};
      else           res = {1'b0, cur + WIDTH'(1)};
    end else begin
      if (cur == '0) res = {1'b1, (sat_m ? {WIDTH{1'b0}} : mx)};
      else           res = {1'b0, cur - WIDTH'(1)};
    end
    return res;
  endfunction

  assign w_tick            = en && (r_psc == psc_div);
  assign {w_bound, w_next} = step_count(r_count, max_val, up_dn, sat);

  // psc free-runs modulo 2^PSC_W, so a psc_div lowered below psc wraps through all-ones to 0.
  always_ff @(posedge clk) begin
    r_tc <= 1'b0;
    if (rst || clr) begin
      r_count <= '0;
      r_psc   <= '0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_psc   <= '0;
    end else if (w_tick) begin
      r_count <= w_next;
      r_psc   <= '0;
      r_tc    <= w_bound;
      r_ovf   <= r_ovf | w_bound;
    end else if (en) begin
      r_psc   <= r_psc + PSC_W'(1);
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

`ifdef PROG_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] r_cap_val;

  // Captures the pre-edge count, so cap with load records the value before the load.
  always_ff @(posedge clk) begin
    if (rst || clr)  r_cap_val <= '0;
    else if (cap)    r_cap_val <= r_count;
  end

  assign cap_val = r_cap_val;
`else
  logic w_unused_cap;
  assign w_unused_cap = cap;
  assign cap_val      = '0;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter (WIDTH=4, PSC_W=4): stimulus pushes expected post-edge outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_prog_counter;

`ifdef PROG_COUNTER_CAPTURE_EN
  localparam bit CAP_ON = 1'b1;
`else
  localparam bit CAP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, clr, en, up_dn, sat, load, cap;
  logic [3:0] load_val, max_val, psc_div;
  logic [3:0] count, cap_val;
  logic       tc, ovf;

  typedef struct {
    logic [3:0] c;
    logic       t;
    logic       o;
    logic [3:0] cv;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  prog_counter #(.WIDTH(4), .PSC_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .sat(sat),
    .load(load), .load_val(load_val), .max_val(max_val), .psc_div(psc_div),
    .cap(cap), .count(count), .tc(tc), .ovf(ovf), .cap_val(cap_val)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  // Monitor: outputs are presented every cycle, checked 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (count !== e.c || tc !== e.t || ovf !== e.o || cap_val !== e.cv) begin
          n_bad++;
          $display("FAIL %s: got count=%0d tc=%0b ovf=%0b cap_val=%0d, want count=%0d tc=%0b ovf=%0b cap_val=%0d",
                   e.nm, count, tc, ovf, cap_val, e.c, e.t, e.o, e.cv);
        end
      end
    end
  end

  // Push the expected outputs after the coming edge, then advance to the next falling edge.
  task automatic cyc(input logic [3:0] c, input logic t, input logic o,
                     input logic [3:0] cv, input string nm);
    exp_t x;
    x.c = c; x.t = t; x.o = o; x.cv = cv; x.nm = nm;
    q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; up_dn = 1'b1; sat = 1'b0;
    load = 1'b0; cap = 1'b0; load_val = 4'd0; max_val = 4'd9; psc_div = 4'd0;
    @(negedge clk);
    cyc(4'd0, 1'b0, 1'b0, 4'd0, "reset0");
    cyc(4'd0, 1'b0, 1'b0, 4'd0, "reset1");

    // Up, wrap, max 9, every cycle a tick
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 9; i++) cyc(4'(i), 1'b0, 1'b0, 4'd0, "up_count");
    cyc(4'd0, 1'b1, 1'b1, 4'd0, "up_wrap_tc");
    cyc(4'd1, 1'b0, 1'b1, 4'd0, "after_wrap");
    clr = 1'b1;
    cyc(4'd0, 1'b0, 1'b0, 4'd0, "clr_after_wrap");
    clr = 1'b0;

    // Down, saturate at zero: tc re-pulses every tick
    up_dn = 1'b0; sat = 1'b1;
    cyc(4'd0, 1'b1, 1'b1, 4'd0, "down_sat1");
    cyc(4'd0, 1'b1, 1'b1, 4'd0, "down_sat2");
    cyc(4'd0, 1'b1, 1'b1, 4'd0, "down_sat3");
    clr = 1'b1;
    cyc(4'd0, 1'b0, 1'b0, 4'd0, "clr_ovf");
    clr = 1'b0; en = 1'b0;
    cyc(4'd0, 1'b0, 1'b0, 4'd0, "hold_en0");

    // Prescaler /4, then en low 2 cycles stretches the period by 2
    up_dn = 1'b1; sat = 1'b0; psc_div = 4'd3; en = 1'b1;
    for (int k = 1; k <= 8; k++) cyc(4'(k / 4), 1'b0, 1'b0, 4'd0, "psc_div3");
    cyc(4'd2, 1'b0, 1'b0, 4'd0, "psc_p1");
    cyc(4'd2, 1'b0, 1'b0, 4'd0, "psc_p2");
    en = 1'b0;
    cyc(4'd2, 1'b0, 1'b0, 4'd0, "psc_gap1");
    cyc(4'd2, 1'b0, 1'b0, 4'd0, "psc_gap2");
    en = 1'b1;
    cyc(4'd2, 1'b0, 1'b0, 4'd0, "psc_p3");
    cyc(4'd3, 1'b0, 1'b0, 4'd0, "psc_stretched_tick");

    // Load above max, then wrap; load coincident with tick wins
    psc_div = 4'd0; load_val = 4'd12; load = 1'b1; en = 1'b0;
    cyc(4'd12, 1'b0, 1'b0, 4'd0, "load12");
    load = 1'b0; en = 1'b1;
    cyc(4'd0, 1'b1, 1'b1, 4'd0, "load_over_max_wrap");
    load = 1'b1;
    cyc(4'd12, 1'b0, 1'b1, 4'd0, "load_beats_tick");
    load = 1'b0; en = 1'b0;
    cyc(4'd12, 1'b0, 1'b1, 4'd0, "hold_after_load");
    sat = 1'b1; en = 1'b1;
    cyc(4'd9, 1'b1, 1'b1, 4'd0, "up_sat_from12");
    cyc(4'd9, 1'b1, 1'b1, 4'd0, "up_sat_repulse");
    sat = 1'b0; up_dn = 1'b0;
    cyc(4'd8, 1'b0, 1'b1, 4'd0, "down_step");
    load_val = 4'd0; load = 1'b1;
    cyc(4'd0, 1'b0, 1'b1, 4'd0, "load0");
    load = 1'b0;
    cyc(4'd9, 1'b1, 1'b1, 4'd0, "down_wrap_to_max");

    // Reset overrides load, cap and tick
    load_val = 4'd5; load = 1'b1;
    cyc(4'd5, 1'b0, 1'b1, 4'd0, "load5");
    rst = 1'b1; cap = 1'b1;
    cyc(4'd0, 1'b0, 1'b0, 4'd0, "rst_over_load");
    rst = 1'b0; load = 1'b0; cap = 1'b0; en = 1'b0; up_dn = 1'b1;
    cyc(4'd0, 1'b0, 1'b0, 4'd0, "post_rst");

    // Capture
    load_val = 4'd7; load = 1'b1;
    cyc(4'd7, 1'b0, 1'b0, 4'd0, "load7");
    load = 1'b0; en = 1'b1; cap = 1'b1;
    cyc(4'd8, 1'b0, 1'b0, CAP_ON ? 4'd7 : 4'd0, "cap7");
    cap = 1'b0;
    cyc(4'd9, 1'b0, 1'b0, CAP_ON ? 4'd7 : 4'd0, "cap_hold");
    load_val = 4'd2; load = 1'b1; cap = 1'b1;
    cyc(4'd2, 1'b0, 1'b0, CAP_ON ? 4'd9 : 4'd0, "cap_preload");
    load = 1'b0; cap = 1'b0; clr = 1'b1;
    cyc(4'd0, 1'b0, 1'b0, 4'd0, "clr_cap");
    clr = 1'b0;

    // Lower psc_div below psc: psc wraps through 15 to 0 before ticking
    psc_div = 4'd5;
    for (int k = 1; k <= 3; k++) cyc(4'd0, 1'b0, 1'b0, 4'd0, "psc_pre");
    psc_div = 4'd1;
    for (int k = 1; k <= 14; k++) cyc(4'd0, 1'b0, 1'b0, 4'd0, "psc_wrapping");
    cyc(4'd1, 1'b0, 1'b0, 4'd0, "psc_wrap_tick");

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
